pwm_audio_seq: RTL and testbench

PWM_AUDIO_SEQ -- requirements
Module: pwm_audio_seq

---
 rtl/pwm_audio_seq_if.sv | 18 +
 rtl/pwm_audio_seq.sv | 145 ++++++++++++++
 tb/tb_pwm_audio_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_audio_seq_if.sv
// rtl/pwm_audio_seq_if.sv - sample handshake bundle between sample source and PWM sequencer
interface pwm_audio_seq_if;
    logic [16:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/pwm_audio_seq.sv
// rtl/pwm_audio_seq.sv - double-buffered PWM audio sequencer with period tick and underrun tracking
module pwm_audio_seq #(
    parameter logic [16:0] PERIOD = 17'd90000
) (
    input  logic               clk,
    input  logic               reset_central,
    input  logic               enable,
    pwm_audio_seq_if.slave     smp,
    output logic [16:0]        contador,
    output logic               pwm_out,
    output logic               period_tick,
    output logic               underrun,
    output logic [7:0]         underrun_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FIRST = 2'd1,
        S_RUN        = 2'd2,
        S_DRAIN      = 2'd3
    } state_t;

    localparam logic [16:0] LAST = PERIOD - 17'd1;

    state_t      st, n_st;
    logic [16:0] cnt, n_cnt;
    logic [16:0] active, n_active;
    logic [16:0] shadow, n_shadow;
    logic        shadow_full, n_shadow_full;
    logic        n_tick, n_underrun, n_pwm;
    logic [7:0]  n_ucount;
    logic        accept, wrap;
    logic [16:0] clamped;

    assign smp.sample_ready = (st == S_WAIT_FIRST) || ((st == S_RUN) && !shadow_full);
    assign accept  = smp.sample_valid && smp.sample_ready;
    assign wrap    = (cnt == LAST);
    assign clamped = (smp.sample_data > PERIOD) ? PERIOD : smp.sample_data;

    assign state    = st;
    assign contador = cnt;

    always_comb begin
        n_st          = st;
        n_cnt         = cnt;
        n_active      = active;
        n_shadow      = shadow;
        n_shadow_full = shadow_full;
        n_tick        = 1'b0;
        n_underrun    = 1'b0;
        n_ucount      = underrun_count;

        case (st)
            S_IDLE: begin
                n_cnt = 17'd0;
                if (enable) begin
                    n_st     = S_WAIT_FIRST;
                    n_ucount = 8'd0;
                end
            end

            S_WAIT_FIRST: begin
                // A sample already handed over is honoured even if enable falls on the same edge.
                if (accept) begin
                    n_active = clamped;
                    n_cnt    = 17'd0;
                    n_tick   = 1'b1;
                    n_st     = S_RUN;
                end else if (!enable) begin
                    n_st = S_IDLE;
                end
            end

            S_RUN: begin
                if (wrap) begin
                    n_cnt  = 17'd0;
                    n_tick = 1'b1;
                    if (shadow_full) begin
                        n_active      = shadow;
                        n_shadow_full = 1'b0;
                    end else if (accept) begin
                        n_active = clamped;
                    end else begin
                        n_underrun = 1'b1;
                        if (underrun_count != 8'hFF)
                            n_ucount = underrun_count + 8'd1;
                    end
                end else begin
                    n_cnt = cnt + 17'd1;
                    if (accept) begin
                        n_shadow      = clamped;
                        n_shadow_full = 1'b1;
                    end
                end
                if (!enable)
                    n_st = S_DRAIN;
            end

            S_DRAIN: begin
                if (wrap) begin
                    n_st          = S_IDLE;
                    n_cnt         = 17'd0;
                    n_active      = 17'd0;
                    n_shadow      = 17'd0;
                    n_shadow_full = 1'b0;
                end else begin
                    n_cnt = cnt + 17'd1;
                    if (enable)
                        n_st = S_RUN;
                end
            end

            default: n_st = S_IDLE;
        endcase

        // Output is registered from next-state values so it stays aligned with contador.
        n_pwm = ((n_st == S_RUN) || (n_st == S_DRAIN)) && (n_cnt < n_active);
    end

    always_ff @(posedge clk or negedge reset_central) begin
        if (!reset_central) begin
            st             <= S_IDLE;
            cnt            <= 17'd0;
            active         <= 17'd0;
            shadow         <= 17'd0;
            shadow_full    <= 1'b0;
            pwm_out        <= 1'b0;
            period_tick    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= 8'd0;
        end else begin
            st             <= n_st;
            cnt            <= n_cnt;
            active         <= n_active;
            shadow         <= n_shadow;
            shadow_full    <= n_shadow_full;
            pwm_out        <= n_pwm;
            period_tick    <= n_tick;
            underrun       <= n_underrun;
            underrun_count <= n_ucount;
        end
    end

endmodule

// File: tb/tb_pwm_audio_seq.sv
// tb/tb_pwm_audio_seq.sv - directed table-driven bench for pwm_audio_seq with PERIOD=10
module tb_pwm_audio_seq;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WF    = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic        clk = 1'b0;
    logic        reset_central;
    logic        enable;
    logic [16:0] contador;
    logic        pwm_out;
    logic        period_tick;
    logic        underrun;
    logic [7:0]  underrun_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    pwm_audio_seq_if sif ();

    pwm_audio_seq #(.PERIOD(17'd10)) dut (
        .clk            (clk),
        .reset_central  (reset_central),
        .enable         (enable),
        .smp            (sif),
        .contador       (contador),
        .pwm_out        (pwm_out),
        .period_tick    (period_tick),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        vld;
        logic [16:0] data;
        logic [1:0]  st;
        logic [16:0] cnt;
        logic        pwm;
        logic        tick;
        logic        rdy;
        logic        ur;
        logic [7:0]  uc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic vld, input int d, input logic [1:0] st,
                       input int c, input logic pwm, input logic tick, input logic rdy,
                       input logic ur, input int uc);
        vec_t v;
        v.en = en; v.vld = vld; v.data = 17'(d); v.st = st; v.cnt = 17'(c);
        v.pwm = pwm; v.tick = tick; v.rdy = rdy; v.ur = ur; v.uc = 8'(uc);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [1:0] st, input int c, input logic pwm,
                             input logic tick, input logic rdy, input logic ur, input int uc);
        check("state", idx, 32'(state), 32'(st));
        check("contador", idx, 32'(contador), 32'(c));
        check("pwm_out", idx, 32'(pwm_out), 32'(pwm));
        check("period_tick", idx, 32'(period_tick), 32'(tick));
        check("sample_ready", idx, 32'(sif.sample_ready), 32'(rdy));
        check("underrun", idx, 32'(underrun), 32'(ur));
        check("underrun_count", idx, 32'(underrun_count), 32'(uc));
    endtask

    initial begin
        int accepts;
        int waited;

        reset_central    = 1'b0;
        enable           = 1'b0;
        sif.sample_valid = 1'b0;
        sif.sample_data  = 17'd0;

        // first period: duty 4, shadow takes 7
        add(1, 0, 0,  S_WF,  0, 0, 0, 1, 0, 0);
        add(1, 1, 4,  S_RUN, 0, 1, 1, 1, 0, 0);
        add(1, 1, 7,  S_RUN, 1, 1, 0, 0, 0, 0);
        for (int c = 2; c <= 9; c++) add(1, 0, 0, S_RUN, c, c < 4, 0, 0, 0, 0);
        // wrap loads 7 from shadow
        add(1, 0, 0, S_RUN, 0, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 9; c++) add(1, 0, 0, S_RUN, c, c < 7, 0, 1, 0, 0);
        // wrap with nothing buffered: underrun, duty stays 7
        add(1, 0, 0, S_RUN, 0, 1, 1, 1, 1, 1);
        for (int c = 1; c <= 9; c++) add(1, 0, 0, S_RUN, c, c < 7, 0, 1, 0, 1);
        // acceptance on the wrap edge: 15 clamps to 10, no underrun
        add(1, 1, 15, S_RUN, 0, 1, 1, 1, 0, 1);
        add(1, 1, 0,  S_RUN, 1, 1, 0, 0, 0, 1);
        for (int c = 2; c <= 9; c++) add(1, 1, 0, S_RUN, c, 1, 0, 0, 0, 1);
        add(1, 1, 0, S_RUN, 0, 0, 1, 1, 0, 1);
        add(1, 1, 5, S_RUN, 1, 0, 0, 0, 0, 1);
        for (int c = 2; c <= 9; c++) add(1, 0, 0, S_RUN, c, 0, 0, 0, 0, 1);
        add(1, 0, 0, S_RUN, 0, 1, 1, 1, 0, 1);
        for (int c = 1; c <= 3; c++) add(1, 0, 0, S_RUN, c, 1, 0, 1, 0, 1);
        // drop enable at contador=3: drain to end of period then idle
        add(0, 0, 0, S_DRAIN, 4, 1, 0, 0, 0, 1);
        for (int c = 5; c <= 9; c++) add(0, 0, 0, S_DRAIN, c, 0, 0, 0, 0, 1);
        add(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, 1);
        // restart clears the underrun count; drain then re-enable at contador=6
        add(1, 0, 0, S_WF,  0, 0, 0, 1, 0, 0);
        add(1, 1, 3, S_RUN, 0, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 3; c++) add(1, 0, 0, S_RUN, c, c < 3, 0, 1, 0, 0);
        add(0, 0, 0, S_DRAIN, 4, 0, 0, 0, 0, 0);
        add(0, 0, 0, S_DRAIN, 5, 0, 0, 0, 0, 0);
        add(0, 0, 0, S_DRAIN, 6, 0, 0, 0, 0, 0);
        add(1, 0, 0, S_RUN, 7, 0, 0, 1, 0, 0);
        add(1, 0, 0, S_RUN, 8, 0, 0, 1, 0, 0);
        add(1, 0, 0, S_RUN, 9, 0, 0, 1, 0, 0);
        add(1, 0, 0, S_RUN, 0, 1, 1, 1, 1, 1);

        // reset held across clock edges
        repeat (3) @(posedge clk);
        #1;
        check_all(-1, S_IDLE, 0, 0, 0, 0, 0, 0);
        reset_central = 1'b1;

        foreach (vecs[i]) begin
            enable           = vecs[i].en;
            sif.sample_valid = vecs[i].vld;
            sif.sample_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].st, int'(vecs[i].cnt), vecs[i].pwm, vecs[i].tick,
                      vecs[i].rdy, vecs[i].ur, int'(vecs[i].uc));
        end

        // asynchronous reset mid-period at contador=5
        enable = 1'b1;
        sif.sample_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_cnt", 0, 32'(contador), 32'd5);
        #2;
        reset_central = 1'b0;
        #1;
        check_all(100, S_IDLE, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all(101, S_IDLE, 0, 0, 0, 0, 0, 0);
        reset_central = 1'b1;
        @(posedge clk);
        #1;
        check_all(102, S_WF, 0, 0, 0, 1, 0, 0);

        // long starvation saturates the underrun counter
        sif.sample_valid = 1'b1;
        sif.sample_data  = 17'd2;
        @(posedge clk);
        #1;
        check_all(103, S_RUN, 0, 1, 1, 1, 0, 0);
        sif.sample_valid = 1'b0;
        repeat (2600) @(posedge clk);
        #1;
        check("sat_count", 104, 32'(underrun_count), 32'd255);
        check("sat_state", 104, 32'(state), 32'(S_RUN));

        // continuous valid: one acceptance per period
        waited = 0;
        while (!period_tick && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("tick_found", 105, 32'(period_tick), 32'd1);
        sif.sample_valid = 1'b1;
        sif.sample_data  = 17'd6;
        accepts = 0;
        for (int i = 0; i < 30; i++) begin
            if (sif.sample_valid && sif.sample_ready) accepts++;
            if (i == 5) check("ready_shadow_full", 106, 32'(sif.sample_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("accepts_per_period", 107, 32'(accepts), 32'd3);
        check("duty6_cnt", 108, 32'(contador), 32'd0);
        check("duty6_pwm", 108, 32'(pwm_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
